// File: rtl/tile_stream_unit_if.sv
// ============================================================================
// Module : tile_stream_unit_if
// Brief  : Input-vector / output-beat handshake bundle for tile_stream_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tile_stream_unit_if #(
    parameter int DATA_W    = 16,
    parameter int IN_ELEMS  = 64,
    parameter int OUT_LANES = 16,
    parameter int RPT_W     = 4
);
    logic [IN_ELEMS*DATA_W-1:0]  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [RPT_W-1:0]            cfg_repeat;
    logic                        cfg_mode;
    logic [OUT_LANES*DATA_W-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic                        busy;

    modport master (
        output in_data, in_valid, cfg_repeat, cfg_mode, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, cfg_repeat, cfg_mode, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/tile_stream_unit.sv
// ============================================================================
// Module : tile_stream_unit
// Brief  : Captures one input vector and streams its element-repeat or
//          vector-tile expansion as OUT_LANES-wide beats. Define
//          TILE_STREAM_PINGPONG_EN for a second capture buffer (no bubble).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_stream_unit #(
    parameter int DATA_W     = 16,
    parameter int IN_ELEMS   = 64,
    parameter int OUT_LANES  = 16,
    parameter int MAX_REPEAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tile_stream_unit_if.slave tsu_io
);
    localparam int RPT_W  = $clog2(MAX_REPEAT + 1);
    localparam int BPV    = IN_ELEMS / OUT_LANES;
    localparam int IDX_W  = (IN_ELEMS > 1) ? $clog2(IN_ELEMS) : 1;
    localparam int BEAT_W = $clog2(MAX_REPEAT * BPV + 1);
    localparam int VEC_W  = IN_ELEMS * DATA_W;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]        state_q,    state_d;
    logic [VEC_W-1:0]  act_data_q, act_data_d;
    logic [RPT_W-1:0]  act_rpt_q,  act_rpt_d;
    logic              act_mode_q, act_mode_d;
    logic [BEAT_W-1:0] last_q,     last_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;
    logic [IDX_W-1:0]  src_q,      src_d;
    logic [RPT_W-1:0]  rep_q,      rep_d;
`ifdef TILE_STREAM_PINGPONG_EN
    logic [VEC_W-1:0]  pend_data_q, pend_data_d;
    logic [RPT_W-1:0]  pend_rpt_q,  pend_rpt_d;
    logic              pend_mode_q, pend_mode_d;
    logic              pend_full_q, pend_full_d;
`endif

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last;
    logic              w_load;
    logic              w_ld_pend;
    logic [VEC_W-1:0]  w_ld_data;
    logic [RPT_W-1:0]  w_ld_rpt;
    logic              w_ld_mode;
    logic [RPT_W-1:0]  w_cfg_r;
    logic [IDX_W-1:0]  w_lane_src [OUT_LANES];
    logic [IDX_W-1:0]  w_s;
    logic [RPT_W-1:0]  w_r;
    logic [IDX_W-1:0]  w_next_src;
    logic [RPT_W-1:0]  w_next_rep;
    logic [OUT_LANES*DATA_W-1:0] w_out_data;

`ifdef TILE_STREAM_PINGPONG_EN
    assign tsu_io.in_ready = !pend_full_q;
    assign tsu_io.busy     = (state_q == S_STREAM) || pend_full_q;
`else
    assign tsu_io.in_ready = (state_q == S_IDLE);
    assign tsu_io.busy     = (state_q == S_STREAM);
`endif
    assign tsu_io.out_valid = (state_q == S_STREAM);
    assign tsu_io.out_last  = (state_q == S_STREAM) && w_last;
    assign tsu_io.out_data  = w_out_data;

    assign w_in_fire  = tsu_io.in_valid && tsu_io.in_ready;
    assign w_out_fire = tsu_io.out_valid && tsu_io.out_ready;
    assign w_last     = (beat_q == last_q);

    always_comb begin
        if (tsu_io.cfg_repeat == '0)
            w_cfg_r = RPT_W'(1);
        else if (tsu_io.cfg_repeat > RPT_W'(MAX_REPEAT))
            w_cfg_r = RPT_W'(MAX_REPEAT);
        else
            w_cfg_r = tsu_io.cfg_repeat;
    end

    // Walk the lanes of the current beat with a source/repeat counter pair;
    // the values after the last lane seed the next beat.
    always_comb begin
        w_s = src_q;
        w_r = rep_q;
        for (int j = 0; j < OUT_LANES; j++) begin
            if (act_mode_q) begin
                w_lane_src[j] = src_q + IDX_W'(j);
            end else begin
                w_lane_src[j] = w_s;
                if (w_r == act_rpt_q - RPT_W'(1)) begin
                    w_r = '0;
                    w_s = w_s + IDX_W'(1);
                end else begin
                    w_r = w_r + RPT_W'(1);
                end
            end
        end
        if (act_mode_q) begin
            w_next_src = (src_q == IDX_W'(IN_ELEMS - OUT_LANES)) ? '0
                                                                 : src_q + IDX_W'(OUT_LANES);
            w_next_rep = '0;
        end else begin
            w_next_src = w_s;
            w_next_rep = w_r;
        end
    end

    always_comb begin
        w_out_data = '0;
        if (state_q == S_STREAM) begin
            for (int j = 0; j < OUT_LANES; j++)
                w_out_data[j*DATA_W +: DATA_W] = act_data_q[int'(w_lane_src[j])*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        act_data_d = act_data_q;
        act_rpt_d  = act_rpt_q;
        act_mode_d = act_mode_q;
        last_d     = last_q;
        beat_d     = beat_q;
        src_d      = src_q;
        rep_d      = rep_q;
        w_load     = 1'b0;
        w_ld_pend  = 1'b0;
`ifdef TILE_STREAM_PINGPONG_EN
        pend_data_d = pend_data_q;
        pend_rpt_d  = pend_rpt_q;
        pend_mode_d = pend_mode_q;
        pend_full_d = pend_full_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_in_fire) begin
                    w_load  = 1'b1;
                    state_d = S_STREAM;
                end
            end
            default: begin
                if (w_out_fire) begin
                    if (w_last) begin
`ifdef TILE_STREAM_PINGPONG_EN
                        if (pend_full_q) begin
                            w_load      = 1'b1;
                            w_ld_pend   = 1'b1;
                            pend_full_d = 1'b0;
                        end else if (w_in_fire) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        src_d  = w_next_src;
                        rep_d  = w_next_rep;
                    end
                end
            end
        endcase

`ifdef TILE_STREAM_PINGPONG_EN
        // A vector arriving mid-stream parks in the second buffer unless the
        // current vector finishes in the same cycle, in which case it goes live.
        if (w_in_fire && !w_load) begin
            pend_data_d = tsu_io.in_data;
            pend_rpt_d  = w_cfg_r;
            pend_mode_d = tsu_io.cfg_mode;
            pend_full_d = 1'b1;
        end
        w_ld_data = w_ld_pend ? pend_data_q : tsu_io.in_data;
        w_ld_rpt  = w_ld_pend ? pend_rpt_q  : w_cfg_r;
        w_ld_mode = w_ld_pend ? pend_mode_q : tsu_io.cfg_mode;
`else
        w_ld_data = tsu_io.in_data;
        w_ld_rpt  = w_cfg_r;
        w_ld_mode = tsu_io.cfg_mode;
`endif

        if (w_load) begin
            act_data_d = w_ld_data;
            act_rpt_d  = w_ld_rpt;
            act_mode_d = w_ld_mode;
            last_d     = BEAT_W'(w_ld_rpt) * BEAT_W'(BPV) - BEAT_W'(1);
            beat_d     = '0;
            src_d      = '0;
            rep_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            act_data_q <= '0;
            act_rpt_q  <= RPT_W'(1);
            act_mode_q <= 1'b0;
            last_q     <= '0;
            beat_q     <= '0;
            src_q      <= '0;
            rep_q      <= '0;
`ifdef TILE_STREAM_PINGPONG_EN
            pend_data_q <= '0;
            pend_rpt_q  <= RPT_W'(1);
            pend_mode_q <= 1'b0;
            pend_full_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            act_data_q <= act_data_d;
            act_rpt_q  <= act_rpt_d;
            act_mode_q <= act_mode_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            src_q      <= src_d;
            rep_q      <= rep_d;
`ifdef TILE_STREAM_PINGPONG_EN
            pend_data_q <= pend_data_d;
            pend_rpt_q  <= pend_rpt_d;
            pend_mode_q <= pend_mode_d;
            pend_full_q <= pend_full_d;
`endif
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_tile_stream_unit.sv
// ============================================================================
// Module : tb_tile_stream_unit
// Brief  : Directed, table-driven self-checking bench for tile_stream_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tile_stream_unit;
    localparam int DW = 16;
    localparam int IE = 8;
    localparam int OL = 4;
    localparam int MR = 8;
    localparam int RW = 4;
`ifdef TILE_STREAM_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_stream_unit_if #(.DATA_W(DW), .IN_ELEMS(IE), .OUT_LANES(OL), .RPT_W(RW)) bus ();

    tile_stream_unit #(
        .DATA_W(DW), .IN_ELEMS(IE), .OUT_LANES(OL), .MAX_REPEAT(MR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tsu_io(bus)
    );

    typedef struct {
        bit         mode;
        logic [3:0] rpt;
        int         eff_r;
        int         beats;
        bit         stall;
        logic [15:0] base;
    } vec_t;

    typedef struct {
        bit          v;
        logic [63:0] d;
        bit          l;
        bit          ir;
        bit          bz;
    } cyc_t;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] hand_beats [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] mkvec(input logic [15:0] base);
        logic [127:0] v;
        for (int i = 0; i < IE; i++) v[i*DW +: DW] = base + 16'(i);
        return v;
    endfunction

    function automatic logic [63:0] model(input bit mode, input int r, input logic [15:0] base, input int b);
        logic [63:0] m;
        int k, src;
        for (int j = 0; j < OL; j++) begin
            k   = b * OL + j;
            src = mode ? (k % IE) : (k / r);
            m[j*DW +: DW] = base + 16'(src);
        end
        return m;
    endfunction

    // Entered and left one time unit after a rising edge with the DUT idle.
    task automatic run_stream(input bit mode, input logic [3:0] rpt, input int eff_r, input int nbeats,
                              input bit stall, input logic [15:0] base, input bit hand, input string nm);
        int b;
        int cyc;
        bit done;
        logic [63:0] exp;
        bus.in_data    = mkvec(base);
        bus.cfg_mode   = mode;
        bus.cfg_repeat = rpt;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        #1;
        chk({nm, " in_ready idle"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.in_data    = {8{16'hdead}};
        bus.cfg_mode   = ~mode;
        bus.cfg_repeat = rpt ^ 4'h5;
        b = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            bus.out_ready = (stall && (cyc % 3 == 1)) ? 1'b0
                          : (stall ? ($urandom_range(0, 3) != 0) : 1'b1);
            #1;
            exp = hand ? hand_beats[b] : model(mode, eff_r, base, b);
            chk($sformatf("%s valid b%0d", nm, b), 64'(bus.out_valid), 64'(1));
            chk($sformatf("%s in_ready b%0d", nm, b), 64'(bus.in_ready), 64'(PP));
            chk($sformatf("%s data b%0d", nm, b), bus.out_data, exp);
            chk($sformatf("%s last b%0d", nm, b), 64'(bus.out_last), 64'(b == nbeats - 1));
            if (bus.out_ready && bus.out_valid) begin
                if (b == nbeats - 1) done = 1'b1;
                b++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " beat count"}, 64'(b), 64'(nbeats));
        bus.out_ready = 1'b1;
        #1;
        chk({nm, " valid after last"}, 64'(bus.out_valid), 64'(0));
        chk({nm, " busy after last"}, 64'(bus.busy), 64'(0));
        chk({nm, " in_ready after last"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    vec_t tbl [6];
    cyc_t pp [8];
    bit hs;

    initial begin
        hand_beats[0] = 64'h0011_0011_0010_0010;
        hand_beats[1] = 64'h0013_0013_0012_0012;
        hand_beats[2] = 64'h0015_0015_0014_0014;
        hand_beats[3] = 64'h0017_0017_0016_0016;

        tbl[0] = '{1'b0, 4'd2,  2, 4,  1'b0, 16'h0010};
        tbl[1] = '{1'b1, 4'd3,  3, 6,  1'b0, 16'h0010};
        tbl[2] = '{1'b0, 4'd0,  1, 2,  1'b0, 16'h0010};
        tbl[3] = '{1'b1, 4'd15, 8, 16, 1'b0, 16'h0010};
        tbl[4] = '{1'b0, 4'd4,  4, 8,  1'b1, 16'h0010};
        tbl[5] = '{1'b0, 4'd15, 8, 16, 1'b0, 16'h0030};

`ifdef TILE_STREAM_PINGPONG_EN
        pp[0] = '{1'b1, hand_beats[0], 1'b0, 1'b1, 1'b1};
        pp[1] = '{1'b1, hand_beats[1], 1'b0, 1'b0, 1'b1};
        pp[2] = '{1'b1, hand_beats[2], 1'b0, 1'b0, 1'b1};
        pp[3] = '{1'b1, hand_beats[3], 1'b1, 1'b0, 1'b1};
        pp[4] = '{1'b1, 64'h0023_0022_0021_0020, 1'b0, 1'b1, 1'b1};
        pp[5] = '{1'b1, 64'h0027_0026_0025_0024, 1'b1, 1'b1, 1'b1};
        pp[6] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0};
        pp[7] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0};
`else
        pp[0] = '{1'b1, hand_beats[0], 1'b0, 1'b0, 1'b1};
        pp[1] = '{1'b1, hand_beats[1], 1'b0, 1'b0, 1'b1};
        pp[2] = '{1'b1, hand_beats[2], 1'b0, 1'b0, 1'b1};
        pp[3] = '{1'b1, hand_beats[3], 1'b1, 1'b0, 1'b1};
        pp[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0};
        pp[5] = '{1'b1, 64'h0023_0022_0021_0020, 1'b0, 1'b0, 1'b1};
        pp[6] = '{1'b1, 64'h0027_0026_0025_0024, 1'b1, 1'b0, 1'b1};
        pp[7] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0};
`endif

        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.cfg_repeat = '0;
        bus.cfg_mode   = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'(1));
        chk("reset out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset out_last", 64'(bus.out_last), 64'(0));
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset out_data", bus.out_data, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_stream(tbl[i].mode, tbl[i].rpt, tbl[i].eff_r, tbl[i].beats, tbl[i].stall,
                       tbl[i].base, (i == 0), $sformatf("vec%0d", i));

        // Reset asserted while beat 1 of a 4-beat stream is presented.
        bus.in_data = mkvec(16'h0040); bus.cfg_mode = 1'b0; bus.cfg_repeat = 4'd2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        #1;
        chk("rst pre beat1 data", bus.out_data, model(1'b0, 2, 16'h0040, 1));
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst out_last", 64'(bus.out_last), 64'(0));
        chk("rst out_data", bus.out_data, 64'h0);
        @(posedge clk); #1;
        chk("rst held out_valid", 64'(bus.out_valid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_stream(1'b0, 4'd2, 2, 4, 1'b0, 16'h0050, 1'b0, "post_rst");

        // Second vector offered while the first one streams.
        bus.in_data = mkvec(16'h0010); bus.cfg_mode = 1'b0; bus.cfg_repeat = 4'd2;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_data = mkvec(16'h0020); bus.cfg_mode = 1'b1; bus.cfg_repeat = 4'd1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("b2b valid c%0d", c), 64'(bus.out_valid), 64'(pp[c].v));
            if (pp[c].v)
                chk($sformatf("b2b data c%0d", c), bus.out_data, pp[c].d);
            chk($sformatf("b2b last c%0d", c), 64'(bus.out_last), 64'(pp[c].l));
            chk($sformatf("b2b in_ready c%0d", c), 64'(bus.in_ready), 64'(pp[c].ir));
            chk($sformatf("b2b busy c%0d", c), 64'(bus.busy), 64'(pp[c].bz));
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) bus.in_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/tile_stream_unit.md
Name: tile_stream_unit

Overview:
- Parametrised successor to the fixed 64-to-256 tile block in the data_ops path.
- Captures one input vector of IN_ELEMS elements and streams out its replicated expansion in OUT_LANES-wide beats under valid/ready backpressure.
- Two modes:
  - Element-repeat: a a b b …
  - Vector-tile: a b … a b …
- Runtime repeat factor up to MAX_REPEAT. Sits between the activation buffer and the downstream vector/PE feed.

Parameters:
- DATA_W, 16, element width in bits.
- IN_ELEMS, 64, elements per input vector; must be a multiple of OUT_LANES.
- OUT_LANES, 16, elements per output beat.
- MAX_REPEAT, 8, largest legal repeat factor; RPT_W = $clog2(MAX_REPEAT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_ELEMS*DATA_W  input vector; element i at [i*DATA_W +: DATA_W]
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- cfg_repeat  in  RPT_W  repeat factor, sampled with the input handshake
- cfg_mode  in  1  0 = element-repeat, 1 = vector-tile; sampled with the input handshake
- out_data  out  OUT_LANES*DATA_W  output beat; lane 0 at [DATA_W-1:0]
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_last  out  1  final beat of the current vector
- busy  out  1  a vector is held or streaming

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, state=IDLE, all counters 0.
- Effective repeat R:
  - cfg_repeat=0 gives R=1.
  - cfg_repeat>MAX_REPEAT is clamped to MAX_REPEAT.
  - R and mode are latched at the input handshake; later cfg changes do not affect the vector in flight.
- Output stream for one vector:
  - Total elements = IN_ELEMS*R; beats = IN_ELEMS*R/OUT_LANES, always an integer, no padding.
  - Global output index k = beat*OUT_LANES + lane.
  - Element-repeat: source = k / R. Vector-tile: source = k mod IN_ELEMS.
  - Use incrementing source/repeat counters, not dividers. One beat per cycle when out_ready=1.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, R and mode; go to STREAM next cycle.
  - STREAM: in_ready=0 (see optional feature), busy=1, out_valid=1. On out_valid&&out_ready, advance beat. On the handshake of the beat with out_last=1, return to IDLE (out_valid=0 next cycle).
- Latency: the first beat is valid the cycle after the input handshake.
- Backpressure: while out_valid&&!out_ready, out_data, out_last and the beat counter hold stable.
- out_last is high only on the final beat. With R*IN_ELEMS==OUT_LANES there is a single beat, and it has out_last=1.
- Asserting rst_n low mid-stream immediately clears out_valid, busy and counters; the captured vector is discarded.
- Captured data is held in a register buffer. in_data need not stay stable after the handshake.

Optional Feature:
- Macro TILE_STREAM_PINGPONG_EN.
- Defined:
  - Two capture buffers; in_ready is high whenever the non-active buffer is empty, including during STREAM.
  - A vector accepted during STREAM starts on the cycle after the current out_last handshake, with no bubble.
  - If an input handshake and the final-beat handshake occur in the same cycle, both are honoured.
  - busy=1 while either buffer is occupied.
- Undefined: single buffer; in_ready=0 throughout STREAM; one idle cycle between vectors.

Test Plan:
(All tests: IN_ELEMS=8, OUT_LANES=4, MAX_REPEAT=8, inputs 0x10..0x17.)
- Element-repeat, cfg_repeat=2, out_ready=1 -> 4 beats: {10,10,11,11}, {12,12,13,13}, {14,14,15,15}, {16,16,17,17}. out_last only on beat 3. First out_valid one cycle after the handshake.
- Vector-tile, cfg_repeat=3 -> 6 beats: {10..13}, {14..17} repeated 3 times. out_last on beat 5. in_ready=0 until the cycle after the beat 5 handshake.
- cfg_repeat=0 and cfg_repeat=15 -> 2 beats (R=1) and 16 beats (R=8, clamped) respectively. Changing cfg mid-stream leaves the output unchanged.
- Random out_ready stalls during element-repeat R=4 -> out_data and out_last hold while stalled; 8 beats total, no duplication or loss.
- rst_n low after beat 1 of a 4-beat stream -> out_valid=0, busy=0, in_ready=1 during reset. A fresh vector after release restarts from beat 0.
- With TILE_STREAM_PINGPONG_EN: a second vector (0x20..0x27) accepted during stream 1 -> its beat 0 is valid the cycle after stream 1's out_last handshake. Without the macro, in_ready stays 0 and there is a one-cycle gap.
